// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// Holds state encodings, parity modes, the vote and the sample-point math.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PAR      = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int DIV_MIN = 16;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Centre of the bit and the spacing of the side samples around it
    function automatic logic [31:0] half_pt(input logic [31:0] div);
        return div >> 1;
    endfunction

    function automatic logic [31:0] qtr_pt(input logic [31:0] div);
        return div >> 3;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_timer.sv
// Per-bit cycle counter for the UART receiver.
// Produces the three sample strobes and the end-of-bit pulse.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int P_DIV_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [P_DIV_W-1:0] div,
    input  logic               restart,
    output logic [P_DIV_W-1:0] cnt,
    output logic               samp,
    output logic               bit_end
);

    logic [P_DIV_W-1:0] h;
    logic [P_DIV_W-1:0] q;

    assign h       = P_DIV_W'(half_pt(32'(div)));
    assign q       = P_DIV_W'(qtr_pt(32'(div)));
    assign bit_end = (cnt >= div - P_DIV_W'(1));
    assign samp    = (cnt == h - q) || (cnt == h) || (cnt == h + q);

    // The detection cycle itself counts as cnt==0, so a restart lands on 1
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= P_DIV_W'(1);
        end else if (bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + P_DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with majority vote, break detect
// and a per-word error sideband on a valid/ready output.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int P_MAX_BITS    = 9,
    parameter int P_DIV_W       = 16,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    input  logic [P_DIV_W-1:0]    cfg_div,
    input  logic [3:0]            cfg_num_bits,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop,
    output logic [P_MAX_BITS-1:0] uart_word,
    output logic                  uart_word_vld,
    input  logic                  uart_word_rdy,
    output logic                  err_parity,
    output logic                  err_frame,
    output logic                  err_overrun,
    output logic                  brk_det,
    output logic                  busy
);

    localparam logic [3:0] MAXB = 4'(P_MAX_BITS);

    state_t state;
    state_t state_nx;

    logic [P_SYNC_STAGES-1:0] sync;
    logic                     rx_s;

    logic [P_DIV_W-1:0] div_q;
    logic [P_DIV_W-1:0] eff_div;
    logic [P_DIV_W-1:0] cnt;
    logic [P_DIV_W-1:0] h;
    logic [P_DIV_W-1:0] q;
    logic [3:0]         nb_q;
    logic [3:0]         eff_nb;
    logic [3:0]         bidx;
    logic [1:0]         par_q;
    logic [1:0]         eff_par;
    logic               stop_q;
    logic               stop_idx;

    logic samp;
    logic bit_end;
    logic start_go;
    logic done;
    logic stop_pt;
    logic vote;
    logic last_bit;
    logic par_en;
    logic par_err;
    logic brk_now;
    logic pbit;
    logic ferr;
    logic sor;

    logic [2:0]            smp;
    logic [P_MAX_BITS-1:0] data;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[P_SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign rx_s = sync[P_SYNC_STAGES-1];

    assign eff_div = (cfg_div < P_DIV_W'(DIV_MIN)) ? P_DIV_W'(DIV_MIN) : cfg_div;
    assign eff_nb  = (cfg_num_bits < 4'd5 || cfg_num_bits > MAXB) ? MAXB : cfg_num_bits;
    assign eff_par = (cfg_parity == 2'd3) ? PAR_NONE : cfg_parity;

    assign h        = P_DIV_W'(half_pt(32'(div_q)));
    assign q        = P_DIV_W'(qtr_pt(32'(div_q)));
    assign stop_pt  = (cnt == h + q + P_DIV_W'(1));
    assign vote     = vote3(smp[2], smp[1], smp[0]);
    assign last_bit = (bidx == nb_q - 4'd1);
    assign par_en   = (par_q != PAR_NONE);

    assign par_err = (par_q == PAR_EVEN) ? (^data ^ pbit)
                   : (par_q == PAR_ODD)  ? ~(^data ^ pbit)
                   : 1'b0;

    // Break: every bit of the frame, start to last stop, read as zero
    assign brk_now = (data == '0) && !(par_en && pbit) && !(sor | vote);

    uart_bit_timer #(
        .P_DIV_W (P_DIV_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .div     (div_q),
        .restart (start_go),
        .cnt     (cnt),
        .samp    (samp),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:     if (!rx_s) state_nx = S_START;
            S_START:    if (bit_end) state_nx = vote ? S_IDLE : S_DATA;
            S_DATA:     if (bit_end && last_bit) state_nx = par_en ? S_PAR : S_STOP;
            S_PAR:      if (bit_end) state_nx = S_STOP;
            S_STOP:     if (done) state_nx = brk_now ? S_BRK_WAIT : S_IDLE;
            S_BRK_WAIT: if (rx_s) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Completion is at the last stop sample, not the bit end
    always_comb begin
        busy     = (state != S_IDLE);
        start_go = (state == S_IDLE) && !rx_s;
        done     = (state == S_STOP) && stop_pt && (stop_idx == stop_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= P_DIV_W'(DIV_MIN);
            nb_q     <= MAXB;
            par_q    <= PAR_NONE;
            stop_q   <= 1'b0;
            stop_idx <= 1'b0;
            bidx     <= '0;
            smp      <= '0;
            data     <= '0;
            pbit     <= 1'b0;
            ferr     <= 1'b0;
            sor      <= 1'b0;
        end else begin
            if (start_go) begin
                div_q    <= eff_div;
                nb_q     <= eff_nb;
                par_q    <= eff_par;
                stop_q   <= cfg_stop;
                stop_idx <= 1'b0;
                bidx     <= '0;
                data     <= '0;
                pbit     <= 1'b0;
                ferr     <= 1'b0;
                sor      <= 1'b0;
            end
            if (samp) begin
                smp <= {smp[1:0], rx_s};
            end
            if (state == S_DATA && bit_end) begin
                data <= data | (P_MAX_BITS'(vote) << bidx);
                bidx <= bidx + 4'd1;
            end
            if (state == S_PAR && bit_end) begin
                pbit <= vote;
            end
            if (state == S_STOP && stop_pt) begin
                ferr <= ferr | !vote;
                sor  <= sor | vote;
            end
            if (state == S_STOP && bit_end) begin
                stop_idx <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_word     <= '0;
            uart_word_vld <= 1'b0;
            err_parity    <= 1'b0;
            err_frame     <= 1'b0;
            err_overrun   <= 1'b0;
            brk_det       <= 1'b0;
        end else if (done) begin
            if (!uart_word_vld || uart_word_rdy) begin
                uart_word     <= data;
                uart_word_vld <= 1'b1;
                err_parity    <= par_err;
                err_frame     <= ferr | !vote;
                err_overrun   <= 1'b0;
                brk_det       <= brk_now;
            end else begin
                err_overrun <= 1'b1;
            end
        end else if (uart_word_vld && uart_word_rdy) begin
            uart_word_vld <= 1'b0;
            err_parity    <= 1'b0;
            err_frame     <= 1'b0;
            err_overrun   <= 1'b0;
            brk_det       <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Runtime-configurable UART receiver. It is the parametrised successor to the fixed-format receiver.
- Baud divisor, data width (5..P_MAX_BITS), parity mode and stop count are set by ports.
- Input synchroniser, 3-sample majority vote, break detection.
- Per-word error sideband (parity, frame, overrun) on a valid/ready output.
- Sits between the pad and the command/FIFO layer.

Parameters:
P_MAX_BITS, 9, maximum data bits per frame; uart_word width.
P_DIV_W, 16, width of cfg_div.
P_SYNC_STAGES, 2, flops on uart_rx before use (>=2).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
uart_rx  in  1  asynchronous serial line, idle high
cfg_div  in  P_DIV_W  clk cycles per bit; values <16 treated as 16
cfg_num_bits  in  4  data bits, 5..P_MAX_BITS; out-of-range treated as P_MAX_BITS
cfg_parity  in  2  0 none, 1 even, 2 odd, 3 treated as none
cfg_stop  in  1  0 = one stop bit, 1 = two
uart_word  out  P_MAX_BITS  received data, LSB-aligned, unused MSBs zero
uart_word_vld  out  1  word valid
uart_word_rdy  in  1  consumer ready
err_parity  out  1  qualified by vld: parity mismatch
err_frame  out  1  qualified by vld: any stop-bit vote = 0
err_overrun  out  1  qualified by vld: one or more frames were dropped while this word was held
brk_det  out  1  qualified by vld: break condition
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchroniser flops = 1.
- Synchronised rx is rx_s (P_SYNC_STAGES cycles of latency).
- Configuration:
  - cfg_* latched on IDLE->START.
  - Mid-frame changes are ignored.
- Bit timer:
  - cnt runs 0..div-1 per bit.
  - Sample strobes at H-Q, H and H+Q, where H = div>>1 and Q = div>>3.
  - Bit value = majority of the 3 samples.
- States and transitions:
  - IDLE: rx_s==0 -> START, cnt=1.
  - START: at cnt==div-1, vote 0 -> DATA; vote 1 -> IDLE (glitch rejected, no output).
  - DATA: shift voted bit in LSB-first. After the cfg_num_bits-th bit, go to PAR if parity is enabled, else STOP.
  - PAR: store the voted bit, then go to STOP at cnt==div-1.
    - Even: error if (parity bit XOR data) = 1.
    - Odd: error if it = 0.
  - STOP: vote each stop bit; any 0 sets frame_err. Completion at the third sample strobe (cnt==H+Q+1) of the last stop bit, not at the bit end, so back-to-back frames tolerate clock skew.
    - If break (see below): publish, then go to BRK_WAIT.
    - Otherwise: publish, then go to IDLE.
  - BRK_WAIT: stay until rx_s==1, then go to IDLE. No start detection while waiting.
- Break: all data bits 0, parity bit 0 (if enabled) and all stop votes 0 -> brk_det=1, err_frame=1, word=0.
- Publish, when vld==0:
  - uart_word, err_parity, err_frame and brk_det are registered.
  - uart_word_vld=1 on the next cycle.
  - Frames with errors are still delivered.
- Handshake:
  - vld && rdy clears vld and all sideband bits on the next cycle.
  - Word and sideband are stable while vld && !rdy.
- Overrun: publish while vld==1 && !rdy:
  - The new frame is discarded.
  - err_overrun is set on the held word.
- Simultaneous publish and handshake accept in the same cycle: the new frame is loaded, vld stays 1, err_overrun=0.
- Reset mid-frame: immediate return to IDLE; a pending word is lost.
- Minimum start-to-vld latency (8N1): P_SYNC_STAGES + 9*div + H+Q+2 cycles.

Decomposition:
- Package uart_pkg holds:
  - state encodings (IDLE, START, DATA, PAR, STOP, BRK_WAIT);
  - parity-mode constants PAR_NONE/EVEN/ODD;
  - the 3-input majority function vote3;
  - the sample-point derivation (H, Q).
- One sub-module, uart_bit_timer:
  - inputs: latched div, restart;
  - outputs: cnt, sample strobe, bit_end.
- Synchroniser stays inline.

Test Plan:
- cfg_div=868, 8N1, send 0xA5 -> uart_word=0x0A5, vld=1, all errors 0, busy falls after the stop sample.
- 7 bits, even parity, 2 stop, send 0x35 with parity bit 1 (correct value 0) -> word=0x35, err_parity=1, err_frame=0.
- rx low for 100 cycles (div=868), then high -> no vld, busy returns 0 after one bit time, next valid frame 0x3C is received.
- rdy held 0, send 0x11 then 0x22 -> vld with 0x11 held, err_overrun=1. After rdy, vld falls and 0x22 never appears.
- 8N1, line held low 12 bit times -> one word: 0x000, brk_det=1, err_frame=1. No further vld until rx returns high; the frame 0x5A after that is received normally.
- rst pulsed mid-DATA of 0xFF, then a clean 0x81 -> no output for 0xFF, 0x81 received correctly; cfg_div changed mid-frame has no effect on the current frame.
